ahb_rsa_slave: RTL and testbench
================================

AHB_RSA_SLAVE -- requirements
Module: ahb_rsa_slave

Interface
REQ-001 Parameter DATA_WORDS, default 64, number of 32-bit operand/result words (2048 bits).
REQ-002 Ports, clock and reset first:
  HCLK  in  1  sole clock, rising edge.
  HRESET  in  1  reset, synchronous, active-high.
  HSEL  in  1  slave select.
  HADDR  in  32  address; only HADDR[4:0] decoded.
  HTRANS  in  2  transfer type; HTRANS[1]=1 is NONSEQ/SEQ.
  HWRITE  in  1  1=write.
  HSIZE  in  3  transfer size; 3'b010 (word) legal.
  HWDATA  in  32  write data, data phase.
  HREADY  in  1  bus ready.
  HRDATA  out  32  read data, data phase.
  HREADYOUT  out  1  slave ready.
  HRESP  out  2  2'b00 OKAY, 2'b01 ERROR.
  rsa_x  out  2048  operand buffer; word k at bits [32k+31:32k].
  rsa_start  out  1  one-cycle start pulse to core.
  rsa_done  in  1  one-cycle completion pulse from core.
  rsa_result  in  2048  core result, valid when rsa_done=1.

Function
REQ-003 Address phase accepted when HSEL & HREADY & HTRANS[1]; HADDR[4:0], HWRITE, HSIZE registered; data phase is the next cycle.
REQ-004 Register map: 0x00 CTRL (W), 0x04 STATUS (R), 0x10 DATA (R/W); CTRL read returns 0; STATUS write ignored, OKAY.
REQ-005 Legal transfers complete with zero wait states: HREADYOUT=1, HRESP=OKAY.
REQ-006 Illegal transfer (HSIZE!=3'b010 or offset not in {0x00,0x04,0x10}): two-cycle ERROR -- cycle 1 HREADYOUT=0 HRESP=01, cycle 2 HREADYOUT=1 HRESP=01; no state, pointer or buffer change.
REQ-007 FSM states IDLE, LOAD, BUSY, DONE; reset state IDLE.
REQ-008 CTRL write (any data) in IDLE, LOAD or DONE: wptr<=0, rptr<=0, done flag cleared, state<=LOAD; ignored in BUSY.
REQ-009 DATA write in LOAD: buffer word wptr<=HWDATA, wptr<=wptr+1; ignored in IDLE, BUSY, DONE.
REQ-010 Write of word DATA_WORDS-1: state<=BUSY, rsa_start=1 on the following cycle for exactly one cycle; wptr holds DATA_WORDS, further writes ignored.
REQ-011 rsa_done=1 in BUSY: result register<=rsa_result, state<=DONE, rptr<=0; rsa_done outside BUSY ignored.
REQ-012 DATA read in DONE: HRDATA=result word rptr, rptr increments, wraps DATA_WORDS-1 -> 0; in other states returns 0, rptr unchanged.
REQ-013 STATUS read: bit0=(state==DONE), bit1=(state==BUSY), bit2=(state==LOAD), bits[14:8]=wptr, other bits 0.
REQ-014 HRDATA driven only during a read data phase, else 0.
REQ-015 rsa_x drives buffer contents continuously; buffer words not rewritten keep prior values.
REQ-016 CTRL write in same cycle as rsa_done (not BUSY case impossible): in BUSY rsa_done wins, CTRL ignored.
REQ-017 Back-to-back transfers: address phase of next transfer overlaps data phase of current; both serviced, no bubble.

Reset
REQ-018 HRESET=1 at a rising edge: state IDLE, wptr=0, rptr=0, operand buffer and result register 0, rsa_start=0, HREADYOUT=1, HRESP=00, HRDATA=0; any in-flight transfer or core run abandoned, later rsa_done ignored until a new start.

Verification
REQ-019 Bench covers:
  - Reset then STATUS read -> 0x00000000; CTRL write 0xFFFFFFFF, STATUS -> 0x00000004.
  - CTRL write, 64 DATA writes of 0..63 -> rsa_x[31:0]=0, rsa_x[2047:2016]=63, single rsa_start pulse one cycle after last data phase, STATUS -> 0x00004002.
  - In BUSY, pulse rsa_done with rsa_result word k = k+0x100 -> STATUS bit0=1; 64 DATA reads return 0x100..0x13F, 65th read returns 0x100.
  - HSIZE=3'b000 write to 0x10 in LOAD -> two-cycle ERROR, wptr unchanged; write to offset 0x08 -> ERROR.
  - DATA writes and CTRL write during BUSY -> ignored, wptr stays 64, STATUS bit1 stays 1.
  - HRESET asserted after 30 DATA writes -> STATUS 0, rsa_x 0; subsequent rsa_done ignored.

Source files
------------

// File: rtl/ahb_rsa_slave.sv
// AHB-Lite slave that fronts an RSA core: loads the operand buffer word by word,
// fires a start pulse, captures the result and serves it back through a read pointer.
module ahb_rsa_slave #(
    parameter int unsigned DATA_WORDS = 64
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     HSEL,
    input  logic [31:0]              HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [31:0]              HWDATA,
    input  logic                     HREADY,
    output logic [31:0]              HRDATA,
    output logic                     HREADYOUT,
    output logic [1:0]               HRESP,
    output logic [DATA_WORDS*32-1:0] rsa_x,
    output logic                     rsa_start,
    input  logic                     rsa_done,
    input  logic [DATA_WORDS*32-1:0] rsa_result
);

    localparam int unsigned WP_W = $clog2(DATA_WORDS + 1);
    localparam int unsigned RP_W = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam logic [4:0]  OFS_CTRL   = 5'h00;
    localparam logic [4:0]  OFS_STATUS = 5'h04;
    localparam logic [4:0]  OFS_DATA   = 5'h10;

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, DONE} state_e;

    state_e                      state_q, state_d;
    logic [WP_W-1:0]             wptr_q, wptr_d;
    logic [RP_W-1:0]             rptr_q, rptr_d;
    logic [DATA_WORDS-1:0][31:0] buf_q, buf_d;
    logic [DATA_WORDS-1:0][31:0] res_q, res_d;
    logic                        start_q, start_d;
    logic                        dp_valid_q, dp_write_q, err2_q;
    logic [4:0]                  dp_addr_q;
    logic [2:0]                  dp_size_q;
    logic                        accept, legal, dp_ok, dp_err;
    logic [31:0]                 status;
    logic                        unused_bits;

    assign unused_bits = ^{HADDR[31:5], HTRANS[0]};
    assign accept = HSEL & HREADY & HTRANS[1];
    assign legal  = (dp_size_q == 3'b010) &&
                    (dp_addr_q == OFS_CTRL || dp_addr_q == OFS_STATUS || dp_addr_q == OFS_DATA);
    assign dp_ok  = dp_valid_q & legal;
    assign dp_err = dp_valid_q & ~legal;

    assign rsa_x     = buf_q;
    assign rsa_start = start_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            buf_q      <= '0;
            res_q      <= '0;
            start_q    <= 1'b0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
            dp_size_q  <= '0;
            err2_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            buf_q      <= buf_d;
            res_q      <= res_d;
            start_q    <= start_d;
            dp_valid_q <= accept;
            err2_q     <= dp_err;
            if (accept) begin
                dp_write_q <= HWRITE;
                dp_addr_q  <= HADDR[4:0];
                dp_size_q  <= HSIZE;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        buf_d   = buf_q;
        res_d   = res_q;
        start_d = 1'b0;
        if (dp_ok && dp_write_q) begin
            if (dp_addr_q == OFS_CTRL && state_q != BUSY) begin
                wptr_d  = '0;
                rptr_d  = '0;
                state_d = LOAD;
            end else if (dp_addr_q == OFS_DATA && state_q == LOAD) begin
                buf_d[wptr_q[RP_W-1:0]] = HWDATA;
                wptr_d = wptr_q + 1'b1;
                if (wptr_q == WP_W'(DATA_WORDS - 1)) begin
                    state_d = BUSY;
                    start_d = 1'b1;
                end
            end
        end
        if (dp_ok && !dp_write_q && dp_addr_q == OFS_DATA && state_q == DONE)
            rptr_d = (rptr_q == RP_W'(DATA_WORDS - 1)) ? '0 : rptr_q + 1'b1;
        // CTRL writes cannot leave BUSY, so a completion in the same cycle needs no arbitration
        if (rsa_done && state_q == BUSY) begin
            res_d   = rsa_result;
            state_d = DONE;
            rptr_d  = '0;
        end
    end

    always_comb begin
        status        = '0;
        status[0]     = (state_q == DONE);
        status[1]     = (state_q == BUSY);
        status[2]     = (state_q == LOAD);
        status[14:8]  = 7'(wptr_q);
        HREADYOUT     = ~dp_err;
        HRESP         = (dp_err | err2_q) ? 2'b01 : 2'b00;
        HRDATA        = '0;
        if (dp_ok && !dp_write_q) begin
            if (dp_addr_q == OFS_STATUS)
                HRDATA = status;
            else if (dp_addr_q == OFS_DATA && state_q == DONE)
                HRDATA = res_q[rptr_q];
        end
    end

endmodule

// File: tb/tb_ahb_rsa_slave.sv
// Randomised AHB bench for ahb_rsa_slave, checked cycle by cycle against a transaction-level model.
module tb_ahb_rsa_slave;
    localparam int N = 64;

    typedef enum {M_IDLE, M_LOAD, M_BUSY, M_DONE} mstate_t;

    logic          HCLK = 1'b0;
    logic          hreset, hsel, hwrite, hready, hreadyout, rsa_start, rsa_done;
    logic [31:0]   haddr, hwdata, hrdata;
    logic [1:0]    htrans, hresp;
    logic [2:0]    hsize;
    logic [N*32-1:0] rsa_x, rsa_result;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    mstate_t     m_state;
    int          m_wptr, m_rptr;
    logic [31:0] m_buf [N];
    logic [31:0] m_res [N];
    bit          exp_start, err2;
    bit          p_valid, p_write;
    logic [4:0]  p_addr;
    logic [2:0]  p_size;
    logic [31:0] p_wd;
    logic [31:0] rd_log [$];
    logic [31:0] w;

    assign hready = hreadyout;

    always #5 HCLK = ~HCLK;

    ahb_rsa_slave #(.DATA_WORDS(N)) dut (
        .HCLK(HCLK), .HRESET(hreset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp),
        .rsa_x(rsa_x), .rsa_start(rsa_start), .rsa_done(rsa_done), .rsa_result(rsa_result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] r;
        r       = '0;
        r[0]    = (m_state == M_DONE);
        r[1]    = (m_state == M_BUSY);
        r[2]    = (m_state == M_LOAD);
        r[14:8] = 7'(m_wptr);
        return r;
    endfunction

    task automatic model_clear();
        m_state = M_IDLE; m_wptr = 0; m_rptr = 0;
        for (int k = 0; k < N; k++) begin m_buf[k] = '0; m_res[k] = '0; end
        exp_start = 0; err2 = 0; p_valid = 0; p_write = 0; p_addr = '0; p_size = '0; p_wd = '0;
    endtask

    // One bus cycle: data phase of the pending transfer plus address phase of a new one.
    task automatic step(input bit v, input bit wr_en, input logic [4:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input bit dn);
        logic [31:0] exp_rd;
        logic        exp_rdy;
        logic [1:0]  exp_resp;
        bit          lg;
        mstate_t     was;
        hwdata   = (p_valid && p_write) ? p_wd : $urandom();
        hsel     = v ? 1'b1 : 1'($urandom_range(0, 1));
        htrans   = v ? {1'b1, 1'($urandom_range(0, 1))} : {1'b0, 1'($urandom_range(0, 1))};
        haddr    = {27'($urandom()), a};
        hwrite   = wr_en;
        hsize    = sz;
        rsa_done = dn;
        #3;
        lg       = (p_size == 3'b010) && (p_addr == 5'h00 || p_addr == 5'h04 || p_addr == 5'h10);
        exp_rdy  = 1'b1;
        exp_resp = err2 ? 2'b01 : 2'b00;
        exp_rd   = '0;
        if (p_valid && !lg) begin
            exp_rdy  = 1'b0;
            exp_resp = 2'b01;
        end else if (p_valid && !p_write) begin
            if (p_addr == 5'h04) exp_rd = m_status();
            else if (p_addr == 5'h10 && m_state == M_DONE) exp_rd = m_res[m_rptr];
            rd_log.push_back(hrdata);
        end
        check("HREADYOUT", 32'(hreadyout), 32'(exp_rdy));
        check("HRESP", 32'(hresp), 32'(exp_resp));
        check("HRDATA", hrdata, exp_rd);
        check("rsa_start", 32'(rsa_start), 32'(exp_start));
        err2      = p_valid && !lg;
        exp_start = 0;
        was       = m_state;
        if (p_valid && lg) begin
            if (p_write && p_addr == 5'h00 && m_state != M_BUSY) begin
                m_wptr = 0; m_rptr = 0; m_state = M_LOAD;
            end else if (p_write && p_addr == 5'h10 && m_state == M_LOAD) begin
                m_buf[m_wptr] = p_wd;
                m_wptr++;
                if (m_wptr == N) begin m_state = M_BUSY; exp_start = 1; end
            end else if (!p_write && p_addr == 5'h10 && m_state == M_DONE) begin
                m_rptr = (m_rptr + 1) % N;
            end
        end
        if (dn && was == M_BUSY) begin
            for (int k = 0; k < N; k++) m_res[k] = rsa_result[k*32 +: 32];
            m_state = M_DONE;
            m_rptr  = 0;
        end
        p_valid = v && !err2;
        p_write = wr_en; p_addr = a; p_size = sz; p_wd = wd;
        @(posedge HCLK);
        #1;
        rsa_done = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        step(1, 1, a, 3'b010, d, 0);
    endtask

    task automatic rd(input logic [4:0] a);
        step(1, 0, a, 3'b010, '0, 0);
    endtask

    task automatic idle(input bit dn);
        step(0, 0, 5'h00, 3'b010, '0, dn);
    endtask

    task automatic rst();
        hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; rsa_done = 1'b0;
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        hreset = 1'b0;
        model_clear();
    endtask

    task automatic chk_x();
        for (int k = 0; k < N; k++)
            check($sformatf("rsa_x[%0d]", k), rsa_x[k*32 +: 32], m_buf[k]);
    endtask

    task automatic status_is(input string tag, input logic [31:0] exp);
        rd(5'h04);
        idle(0);
        check(tag, rd_log[rd_log.size()-1], exp);
    endtask

    initial begin
        hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
        hsize = 3'b010; hwdata = '0; rsa_done = 1'b0; rsa_result = '0;
        rst();
        chk_x();
        status_is("status_after_reset", 32'h0000_0000);
        rd(5'h00); idle(0);
        check("ctrl_read", rd_log[rd_log.size()-1], 32'h0);
        wr(5'h00, 32'hFFFF_FFFF);
        status_is("status_load", 32'h0000_0004);
        wr(5'h04, 32'h1234_5678);
        status_is("status_write_ignored", 32'h0000_0004);

        // directed load 0..N-1, with error transfers injected part way
        wr(5'h00, $urandom());
        for (int k = 0; k < N; k++) begin
            wr(5'h10, 32'(k));
            if ($urandom_range(0, 3) == 0) idle(0);
            if (k == 9) begin
                idle(0);
                step(1, 1, 5'h10, 3'b000, 32'hDEAD_BEEF, 0);
                idle(0); idle(0);
                step(1, 1, 5'h08, 3'b010, 32'hDEAD_BEEF, 0);
                idle(0); idle(0);
                status_is("status_after_err", 32'h0000_0A04);
            end
        end
        idle(0); idle(0); idle(0);
        w = rsa_x[31:0];
        check("rsa_x_first", w, 32'h0);
        w = rsa_x[N*32-1 -: 32];
        check("rsa_x_last", w, 32'd63);
        chk_x();
        status_is("status_busy", 32'h0000_4002);

        // traffic that must be ignored while the core runs
        for (int k = 0; k < 4; k++) wr(5'h10, $urandom());
        wr(5'h00, 32'h0);
        rd(5'h10);
        status_is("status_busy_held", 32'h0000_4002);
        chk_x();

        for (int k = 0; k < N; k++) rsa_result[k*32 +: 32] = 32'h100 + 32'(k);
        idle(1);
        status_is("status_done", 32'h0000_4001);
        rd_log.delete();
        for (int k = 0; k <= N; k++) rd(5'h10);
        idle(0);
        check("read_first", rd_log[0], 32'h100);
        check("read_last", rd_log[N-1], 32'h13F);
        check("read_wrap", rd_log[N], 32'h100);

        // randomised rounds
        for (int r = 0; r < 3; r++) begin
            wr(5'h00, $urandom());
            for (int k = 0; k < N; k++) begin
                wr(5'h10, $urandom());
                case ($urandom_range(0, 7))
                    0: idle(0);
                    1: rd(5'h04);
                    2: idle(1);
                    3: rd(5'h10);
                    default: ;
                endcase
            end
            idle(0);
            for (int k = 0; k < 5; k++) if ($urandom_range(0, 1) == 1) wr(5'h10, $urandom()); else idle(0);
            chk_x();
            for (int k = 0; k < N; k++) rsa_result[k*32 +: 32] = $urandom();
            wr(5'h00, 32'h0);
            step(1, 0, 5'h04, 3'b010, '0, 1);
            for (int k = 0; k < N + 7; k++) begin
                rd(5'h10);
                if ($urandom_range(0, 3) == 0) idle(0);
                if ($urandom_range(0, 9) == 0) rd(5'h04);
            end
            idle(0);
        end

        // reset in the middle of a load
        wr(5'h00, 32'h0);
        for (int k = 0; k < 30; k++) wr(5'h10, $urandom());
        idle(0);
        rst();
        chk_x();
        status_is("status_after_midreset", 32'h0);
        idle(1);
        status_is("status_done_ignored", 32'h0);
        rd(5'h10); idle(0);
        check("data_read_idle", rd_log[rd_log.size()-1], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
